// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants for the hazard/stall control slice.
// State encoding, counter width and the hard-wired zero register index.
package hazard_stall_unit_pkg;

  localparam int CNT_W = 16;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FREEZE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational source-register comparisons feeding the stall FSM.
// Purely combinational; no state and no flow control of its own.
module hazard_match
  import hazard_stall_unit_pkg::*;
(
  input  logic             IFID_isBranch,
  input  logic [REG_W-1:0] IFID_regRs,
  input  logic [REG_W-1:0] IFID_regRt,
  input  logic             IFID_usesRt,
  input  logic             IDEX_memRead,
  input  logic [REG_W-1:0] IDEX_regRt,
  input  logic             IDEX_regWrite,
  input  logic [REG_W-1:0] IDEX_regRd,
  input  logic             EXMEM_memRead,
  input  logic [REG_W-1:0] EXMEM_regRd,
  output logic             load_use,
  output logic             branch_alu,
  output logic             branch_load,
  output logic             branch_mem_load
);

  // Register 0 never creates a dependency; Rt only counts when it is read.
  function automatic logic src_match(input logic [REG_W-1:0] r);
    return (r != REG_ZERO) &&
           ((r == IFID_regRs) || (IFID_usesRt && (r == IFID_regRt)));
  endfunction

  always_comb begin
    load_use        = IDEX_memRead && src_match(IDEX_regRt);
    branch_alu      = IFID_isBranch && IDEX_regWrite && !IDEX_memRead &&
                      src_match(IDEX_regRd);
    branch_load     = IFID_isBranch && IDEX_memRead && src_match(IDEX_regRt);
    branch_mem_load = IFID_isBranch && EXMEM_memRead && src_match(EXMEM_regRd);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: stalls same-cycle on hazards, HOLDs one extra
// cycle for branch-after-load, and FREEZEs the front end while memory is busy.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_regRs,
  input  logic [REG_W-1:0] IFID_regRt,
  input  logic             IFID_usesRt,
  input  logic             IFID_isBranch,
  input  logic             branch_taken,
  input  logic             IDEX_memRead,
  input  logic [REG_W-1:0] IDEX_regRt,
  input  logic             IDEX_regWrite,
  input  logic [REG_W-1:0] IDEX_regRd,
  input  logic             EXMEM_memRead,
  input  logic [REG_W-1:0] EXMEM_regRd,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t     state_q;
  state_t     saved_q;
  state_t     eff_state;
  logic [1:0] remaining_q;
  logic       load_use, branch_alu, branch_load, branch_mem_load;
  logic       haz_any;
  logic       stall;

  hazard_match u_match (
    .IFID_isBranch   (IFID_isBranch),
    .IFID_regRs      (IFID_regRs),
    .IFID_regRt      (IFID_regRt),
    .IFID_usesRt     (IFID_usesRt),
    .IDEX_memRead    (IDEX_memRead),
    .IDEX_regRt      (IDEX_regRt),
    .IDEX_regWrite   (IDEX_regWrite),
    .IDEX_regRd      (IDEX_regRd),
    .EXMEM_memRead   (EXMEM_memRead),
    .EXMEM_regRd     (EXMEM_regRd),
    .load_use        (load_use),
    .branch_alu      (branch_alu),
    .branch_load     (branch_load),
    .branch_mem_load (branch_mem_load)
  );

  assign haz_any = load_use | branch_alu | branch_load | branch_mem_load;

  // On the cycle memory releases, behave as the saved state so no cycle is lost.
  assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

  always_comb begin
    stall = 1'b0;
    case (eff_state)
      IDLE:    stall = haz_any;
      HOLD:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_bubble = 1'b0;
    IFID_flush  = 1'b0;
    if (!rst_n) begin
      PC_write   = 1'b1;
    end else if (mem_busy) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
    end else if (stall) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end else begin
      IFID_flush = branch_taken & IFID_isBranch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      saved_q      <= IDLE;
      remaining_q  <= 2'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (IDEX_bubble) stall_cycles <= sat_inc(stall_cycles);
      if (IFID_flush)  flush_count  <= sat_inc(flush_count);

      if (mem_busy) begin
        state_q <= FREEZE;
        if (state_q != FREEZE) saved_q <= state_q;
      end else begin
        if (state_q == FREEZE) saved_q <= IDLE;
        case (eff_state)
          IDLE: begin
            if (branch_load) begin
              state_q     <= HOLD;
              remaining_q <= 2'd1;
            end else begin
              state_q <= IDLE;
            end
          end
          HOLD: begin
            if (remaining_q > 2'd1) begin
              state_q     <= HOLD;
              remaining_q <= remaining_q - 2'd1;
            end else begin
              state_q     <= IDLE;
              remaining_q <= 2'd0;
            end
          end
          default: begin
            state_q     <= IDLE;
            remaining_q <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with hand-computed expectations.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IFID_regRs, IFID_regRt, IDEX_regRt, IDEX_regRd, EXMEM_regRd;
  logic        IFID_usesRt, IFID_isBranch, branch_taken;
  logic        IDEX_memRead, IDEX_regWrite, EXMEM_memRead, mem_busy;
  logic        PC_write, IFID_write, IDEX_bubble, IFID_flush;
  logic [15:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFID_regRs    (IFID_regRs),
    .IFID_regRt    (IFID_regRt),
    .IFID_usesRt   (IFID_usesRt),
    .IFID_isBranch (IFID_isBranch),
    .branch_taken  (branch_taken),
    .IDEX_memRead  (IDEX_memRead),
    .IDEX_regRt    (IDEX_regRt),
    .IDEX_regWrite (IDEX_regWrite),
    .IDEX_regRd    (IDEX_regRd),
    .EXMEM_memRead (EXMEM_memRead),
    .EXMEM_regRd   (EXMEM_regRd),
    .mem_busy      (mem_busy),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .IDEX_bubble   (IDEX_bubble),
    .IFID_flush    (IFID_flush),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    IFID_regRs = 5'd0; IFID_regRt = 5'd0; IFID_usesRt = 1'b0;
    IFID_isBranch = 1'b0; branch_taken = 1'b0;
    IDEX_memRead = 1'b0; IDEX_regRt = 5'd0;
    IDEX_regWrite = 1'b0; IDEX_regRd = 5'd0;
    EXMEM_memRead = 1'b0; EXMEM_regRd = 5'd0;
    mem_busy = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // pc covers both PC_write and IFID_write, which always move together.
  task automatic chk_out(input string tag, input logic pc, input logic bub, input logic fl);
    #1;
    chk({tag, ".PC_write"},    32'(PC_write),    32'(pc));
    chk({tag, ".IFID_write"},  32'(IFID_write),  32'(pc));
    chk({tag, ".IDEX_bubble"}, 32'(IDEX_bubble), 32'(bub));
    chk({tag, ".IFID_flush"},  32'(IFID_flush),  32'(fl));
  endtask

  initial begin
    clear_in();
    // Reset asserted with every event input active: defaults must still win.
    rst_n = 1'b0; mem_busy = 1'b1; IDEX_memRead = 1'b1; IDEX_regRt = 5'd2;
    IFID_regRs = 5'd2; IFID_isBranch = 1'b1; branch_taken = 1'b1;
    chk_out("rst_force", 1'b1, 1'b0, 1'b0);
    tick(); tick();
    clear_in(); rst_n = 1'b1;
    chk_out("idle", 1'b1, 1'b0, 1'b0);
    chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Load-use through Rs: one stall cycle.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd2; IFID_regRs = 5'd2;
    chk_out("lu_rs", 1'b0, 1'b1, 1'b0);
    tick(); clear_in();
    chk_out("lu_rs_after", 1'b1, 1'b0, 1'b0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Load-use through Rt only counts when Rt is actually read.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd5; IFID_regRs = 5'd6;
    IFID_regRt = 5'd5; IFID_usesRt = 1'b1;
    chk_out("lu_rt", 1'b0, 1'b1, 1'b0);
    IFID_usesRt = 1'b0;
    chk_out("lu_rt_unused", 1'b1, 1'b0, 1'b0);
    tick(); clear_in();
    chk("lu_rt_stall_cnt", 32'(stall_cycles), 32'd1);

    // Register zero never matches.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd0; IFID_regRs = 5'd0;
    IFID_usesRt = 1'b1; IFID_regRt = 5'd0;
    chk_out("zero_reg", 1'b1, 1'b0, 1'b0);
    tick(); clear_in();

    // Branch after load: two stall cycles, IDLE->HOLD->IDLE, taken ignored in HOLD.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd3; IFID_isBranch = 1'b1;
    IFID_regRs = 5'd3; IFID_regRt = 5'd4; IFID_usesRt = 1'b1;
    chk_out("bl_c1", 1'b0, 1'b1, 1'b0);
    tick();
    chk("bl_state_hold", 32'(dut.state_q), 32'(HOLD));
    clear_in(); IFID_isBranch = 1'b1; branch_taken = 1'b1;
    chk_out("bl_c2_taken", 1'b0, 1'b1, 1'b0);
    tick(); clear_in();
    chk("bl_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk_out("bl_done", 1'b1, 1'b0, 1'b0);
    chk("bl_stall_cnt", 32'(stall_cycles), 32'd3);
    chk("bl_flush_cnt", 32'(flush_count), 32'd0);

    // Branch after ALU writer: one cycle; a load in EX masks the ALU check.
    IFID_isBranch = 1'b1; IDEX_regWrite = 1'b1; IDEX_regRd = 5'd7; IFID_regRs = 5'd7;
    chk_out("balu", 1'b0, 1'b1, 1'b0);
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd9;
    chk_out("balu_masked", 1'b1, 1'b0, 1'b0);
    IDEX_memRead = 1'b0;
    tick();
    chk("balu_state", 32'(dut.state_q), 32'(IDLE));
    clear_in();
    chk_out("balu_done", 1'b1, 1'b0, 1'b0);

    // Branch after load in MEM: one cycle.
    IFID_isBranch = 1'b1; EXMEM_memRead = 1'b1; EXMEM_regRd = 5'd8;
    IFID_usesRt = 1'b1; IFID_regRt = 5'd8;
    chk_out("bmem", 1'b0, 1'b1, 1'b0);
    tick();
    chk("bmem_state", 32'(dut.state_q), 32'(IDLE));
    clear_in();
    chk_out("bmem_done", 1'b1, 1'b0, 1'b0);
    chk("bmem_stall_cnt", 32'(stall_cycles), 32'd5);

    // Taken branch with no hazard flushes exactly one cycle.
    IFID_isBranch = 1'b1; branch_taken = 1'b1;
    chk_out("flush", 1'b1, 1'b0, 1'b1);
    tick(); clear_in();
    chk_out("flush_done", 1'b1, 1'b0, 1'b0);
    chk("flush_cnt", 32'(flush_count), 32'd1);

    // Stall beats flush; mem_busy beats both.
    IFID_isBranch = 1'b1; branch_taken = 1'b1;
    IDEX_regWrite = 1'b1; IDEX_regRd = 5'd10; IFID_regRs = 5'd10;
    chk_out("stall_over_flush", 1'b0, 1'b1, 1'b0);
    mem_busy = 1'b1;
    chk_out("busy_over_all", 1'b0, 1'b0, 1'b0);
    tick(); clear_in(); tick();
    chk("prio_stall_cnt", 32'(stall_cycles), 32'd5);
    chk("prio_flush_cnt", 32'(flush_count), 32'd1);

    // mem_busy for three cycles inside HOLD, then the one pending HOLD cycle.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd3; IFID_isBranch = 1'b1; IFID_regRs = 5'd3;
    tick();
    clear_in(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("frz%0d", i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    mem_busy = 1'b0;
    chk_out("frz_hold", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("frz_done", 1'b1, 1'b0, 1'b0);
    chk("frz_state", 32'(dut.state_q), 32'(IDLE));
    chk("frz_stall_cnt", 32'(stall_cycles), 32'd7);

    // Saturate stall_cycles with a held load-use hazard.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd2; IFID_regRs = 5'd2;
    repeat (65535 - 7) tick();
    chk("sat_reach", 32'(stall_cycles), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

    // Reset in the middle of HOLD with saturated counter.
    IFID_isBranch = 1'b1;
    tick();
    chk("rst_mid_state", 32'(dut.state_q), 32'(HOLD));
    rst_n = 1'b0; mem_busy = 1'b1;
    chk_out("rst_mid_force", 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; clear_in();
    chk_out("rst_mid_after", 1'b1, 1'b0, 1'b0);
    chk("rst_mid_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_mid_flush_cnt", 32'(flush_count), 32'd0);
    chk("rst_mid_state_idle", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk_out("rst_mid_no_residual", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of FREEZE.
    IDEX_memRead = 1'b1; IDEX_regRt = 5'd4; IFID_isBranch = 1'b1; IFID_regRs = 5'd4;
    tick();
    clear_in(); mem_busy = 1'b1;
    tick();
    chk("rst_frz_state", 32'(dut.state_q), 32'(FREEZE));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_busy = 1'b0;
    chk_out("rst_frz_after", 1'b1, 1'b0, 1'b0);
    chk("rst_frz_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("rst_frz_stall_cnt", 32'(stall_cycles), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL provide clk, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL provide rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL provide IFID_regRs and IFID_regRt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL provide IFID_usesRt, input, 1 bit: the ID instruction reads Rt as a source.
REQ-005 SHALL provide IFID_isBranch, input, 1 bit: the ID instruction is beq or bne, compared in ID.
REQ-006 SHALL provide branch_taken, input, 1 bit: the ID branch resolved taken this cycle.
REQ-007 SHALL provide IDEX_memRead, input, 1 bit, and IDEX_regRt, input, 5 bits: load in EX and its destination.
REQ-008 SHALL provide IDEX_regWrite, input, 1 bit, and IDEX_regRd, input, 5 bits: ALU writer in EX and its destination.
REQ-009 SHALL provide EXMEM_memRead, input, 1 bit, and EXMEM_regRd, input, 5 bits: load in MEM and its destination.
REQ-010 SHALL provide mem_busy, input, 1 bit: the data memory cannot complete this cycle.
REQ-011 SHALL provide PC_write and IFID_write, output, 1 bit each: 0 freezes the PC and the IF/ID register.
REQ-012 SHALL provide IDEX_bubble, output, 1 bit: 1 loads a NOP into ID/EX.
REQ-013 SHALL provide IFID_flush, output, 1 bit: 1 zeroes IF/ID.
REQ-014 SHALL provide stall_cycles and flush_count, output, 16 bits each: saturating event counters.

Function
REQ-015 SHALL define the matches "rs" as r!=0 & r==IFID_regRs and "rt" as r!=0 & IFID_usesRt & r==IFID_regRt; a source matches r if either holds.
REQ-016 SHALL detect a load-use hazard (1 stall cycle) when IDEX_memRead is 1 and IDEX_regRt matches a source.
REQ-017 SHALL detect a branch-ALU hazard (1 stall cycle) when IFID_isBranch & IDEX_regWrite & !IDEX_memRead and IDEX_regRd matches a source.
REQ-018 SHALL detect a branch-load hazard (2 stall cycles) when IFID_isBranch & IDEX_memRead and IDEX_regRt matches a source.
REQ-019 SHALL detect a branch-MEM-load hazard (1 stall cycle) when IFID_isBranch & EXMEM_memRead and EXMEM_regRd matches a source.
REQ-020 SHALL implement the FSM states IDLE, HOLD and FREEZE, with IDLE entered on reset.
REQ-021 SHALL, in IDLE with any hazard detected, combinationally drive PC_write=0, IFID_write=0 and IDEX_bubble=1 in the same cycle.
REQ-022 SHALL, in IDLE, go to HOLD with remaining=1 only on a 2-cycle hazard; 1-cycle hazards stay in IDLE.
REQ-023 SHALL, in HOLD, drive the stall outputs unconditionally, ignore hazard inputs, and return to IDLE at the cycle end.
REQ-024 SHALL, when mem_busy=1 in any state, drive PC_write=0, IFID_write=0, IDEX_bubble=0 and IFID_flush=0, and enter FREEZE.
REQ-025 SHALL, in FREEZE, save the pre-freeze state and restore it when mem_busy falls; HOLD's remaining count is not consumed while frozen.
REQ-026 SHALL apply output priority mem_busy > hazard stall > flush.
REQ-027 SHALL assert IFID_flush=1 for exactly the cycle with branch_taken=1, IFID_isBranch=1, no stall and no mem_busy.
REQ-028 SHALL ignore branch_taken while a stall is asserted.
REQ-029 SHALL, in IDLE with no event, drive PC_write=1, IFID_write=1, IDEX_bubble=0 and IFID_flush=0.
REQ-030 SHALL increment stall_cycles on every cycle with IDEX_bubble=1 and flush_count on every IFID_flush=1, each saturating at 0xFFFF.

Reset
REQ-031 SHALL, when rst_n=0 at a rising edge, set the state to IDLE, remaining to 0, the FREEZE save slot to IDLE, and both counters to 0.
REQ-032 SHALL force PC_write=1, IFID_write=1, IDEX_bubble=0 and IFID_flush=0 while rst_n=0, regardless of other inputs.
REQ-033 SHALL abandon any HOLD or FREEZE in progress on reset mid-stall, with no residual stall after rst_n rises.

Structure
REQ-034 SHALL place the FSM state encoding (2 bits), the counter width 16, and register index 0 as a named constant in the shared pipeline package.
REQ-035 SHALL implement the four hazard match equations in a single sub-module, hazard_match, which is combinational only; the FSM and counters stay in the top level.

Verification
REQ-036 SHALL cover: lw $2 in EX, add using $2 in ID -> exactly 1 cycle of PC_write=0 and IDEX_bubble=1; stall_cycles=1.
REQ-037 SHALL cover: lw $3 in EX, beq $3,$4 in ID -> 2 consecutive stall cycles with FSM IDLE->HOLD->IDLE; stall_cycles=2.
REQ-038 SHALL cover: IDEX_regRt=0 with memRead and IFID_regRs=0 -> no stall.
REQ-039 SHALL cover: beq taken with no hazard -> IFID_flush=1 for 1 cycle; flush_count=1; a taken branch during HOLD -> no flush.
REQ-040 SHALL cover: mem_busy raised 3 cycles while in HOLD -> all write enables 0 and bubble 0 for 3 cycles, then exactly 1 HOLD stall cycle.
REQ-041 SHALL cover: rst_n=0 mid-HOLD with counters at 0xFFFF -> outputs at defaults next cycle and counters at 0; a separate case preloads 0xFFFF plus 1 stall -> counter stays 0xFFFF.
